timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 134 +++++++++++++
 tb/tb_timer_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// Bank of NCH independent one-shot/auto-reload timers with per-channel limit registers and count readback.
// Optional shared prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_bank #(
    parameter int unsigned NCH       = 3,
    parameter int unsigned CW        = 28,
    parameter int unsigned RST_LIMIT = 1,
    parameter int unsigned PRESCALE  = 25000000,
    localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] start,
    input  logic [NCH-1:0] clear,
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] periodic,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_limit,
    input  logic [CHW-1:0] rd_ch,
    output logic [CW-1:0]  rd_count,
    output logic [NCH-1:0] done,
    output logic [NCH-1:0] tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (NCH < 1 || NCH > 16 || CW < 1 || PRESCALE < 1) begin : g_bad_param
        $error("timer_bank: parameter out of range");
    end

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [CW-1:0]  count_q [NCH];
    logic [CW-1:0]  count_d [NCH];
    logic [CW-1:0]  limit_q [NCH];
    logic [CW-1:0]  limit_d [NCH];
    logic [CW-1:0]  eff_lim [NCH];
    logic [CW:0]    cnt_inc [NCH];
    logic [NCH-1:0] tick_d;
    logic [CW-1:0]  rd_sel;
    logic           strobe;

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;

    // Shared free-running divider; strobe marks the last cycle of each period.
    assign strobe = (pre_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || strobe) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end
`else
    assign strobe = 1'b1;
`endif

    // Per-channel next state: clear beats start beats counting.
    always_comb begin
        tick_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            limit_d[i] = limit_q[i];
            eff_lim[i] = (limit_q[i] == '0) ? CW'(1) : limit_q[i];
            cnt_inc[i] = {1'b0, count_q[i]} + (CW + 1)'(1);

            if (clear[i]) begin
                state_d[i] = S_IDLE;
                count_d[i] = '0;
            end else if (start[i]) begin
                state_d[i] = S_RUN;
                count_d[i] = '0;
            end else if (state_q[i] == S_RUN && en[i] && strobe) begin
                if (cnt_inc[i] >= {1'b0, eff_lim[i]}) begin
                    tick_d[i] = 1'b1;
                    if (periodic[i]) begin
                        count_d[i] = '0;
                    end else begin
                        count_d[i] = eff_lim[i];
                        state_d[i] = S_DONE;
                    end
                end else begin
                    count_d[i] = cnt_inc[i][CW-1:0];
                end
            end

            if (cfg_we && cfg_ch == CHW'(i)) begin
                limit_d[i] = cfg_limit;
            end
        end
    end

    // Readback mux; unmatched (out-of-range) selects read as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                rd_sel = count_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                count_q[i] <= '0;
                limit_q[i] <= CW'(RST_LIMIT);
            end
            done     <= '0;
            tick     <= '0;
            rd_count <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                limit_q[i] <= limit_d[i];
                done[i]    <= (state_d[i] == S_DONE);
            end
            tick     <= tick_d;
            rd_count <= rd_sel;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Randomized scoreboard bench for timer_bank (default build, no prescaler).
module tb_timer_bank;

    localparam int NCH       = 3;
    localparam int CW        = 28;
    localparam int RST_LIMIT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] start, clear, en, periodic, done, tick;
    logic           cfg_we;
    logic [1:0]     cfg_ch, rd_ch;
    logic [CW-1:0]  cfg_limit, rd_count;

    timer_bank #(.NCH(NCH), .CW(CW), .RST_LIMIT(RST_LIMIT)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .en(en),
        .periodic(periodic), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_limit(cfg_limit), .rd_ch(rd_ch), .rd_count(rd_count),
        .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] done;
        logic [NCH-1:0] tick;
        logic [CW-1:0]  rdc;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    bit   stim_done = 1'b0;

    // Reference: each channel is "running" or "expired" with an integer count.
    int m_cnt [NCH];
    int m_lim [NCH];
    bit m_run [NCH];
    bit m_exp [NCH];

    // Apply current inputs to the model, queue the outcome, advance one cycle.
    task automatic step();
        exp_t e;
        e.tick = '0;
        e.done = '0;
        e.rdc  = '0;
        e.cyc  = cyc_n;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0; m_lim[i] = RST_LIMIT; m_run[i] = 0; m_exp[i] = 0;
            end
        end else begin
            if (int'(rd_ch) < NCH) e.rdc = CW'(m_cnt[rd_ch]);
            for (int i = 0; i < NCH; i++) begin
                int target;
                target = (m_lim[i] == 0) ? 1 : m_lim[i];
                if (clear[i]) begin
                    m_run[i] = 0; m_exp[i] = 0; m_cnt[i] = 0;
                end else if (start[i]) begin
                    m_run[i] = 1; m_exp[i] = 0; m_cnt[i] = 0;
                end else if (m_run[i] && en[i]) begin
                    if (m_cnt[i] + 1 >= target) begin
                        e.tick[i] = 1'b1;
                        if (periodic[i]) begin
                            m_cnt[i] = 0;
                        end else begin
                            m_cnt[i] = target; m_run[i] = 0; m_exp[i] = 1;
                        end
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                e.done[i] = m_exp[i];
            end
            if (cfg_we && int'(cfg_ch) < NCH) m_lim[cfg_ch] = int'(cfg_limit);
        end
        sb.push_back(e);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            start  = '0;
            clear  = '0;
            cfg_we = 1'b0;
            rst    = 1'b0;
        end
    endtask

    task automatic write_limit(input int ch, input int lim);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_limit = CW'(lim);
        run(1);
    endtask

    task automatic chk(input string name, input int c, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, c, got, exp);
        end
    endtask

    // Monitor: one registered output set per clock, compared against queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done", e.cyc, CW'(done), CW'(e.done));
                chk("tick", e.cyc, CW'(tick), CW'(e.tick));
                chk("rd_count", e.cyc, rd_count, e.rdc);
            end
        end
    end

    initial begin
        rst = 1'b1; start = '0; clear = '0; en = '0; periodic = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0; rd_ch = '0;
        @(negedge clk);
        rst = 1'b1;
        step(); rst = 1'b1; run(2);

        // One-shot, limit 5 on ch0, hold DONE for 20+ cycles.
        en = 3'b111; rd_ch = 2'd0;
        write_limit(0, 5);
        start = 3'b001; run(26);

        // Periodic, limit 4 on ch1.
        rd_ch = 2'd1; periodic = 3'b010;
        write_limit(1, 4);
        start = 3'b010; run(14);

        // Pause then retrigger on ch2, limit 10.
        rd_ch = 2'd2; periodic = 3'b000;
        write_limit(2, 10);
        start = 3'b100; run(4);
        en = 3'b011; run(3);
        en = 3'b111; run(3);
        start = 3'b100; run(12);

        // Clear and start together during RUN, then reset mid-count.
        start = 3'b100; run(3);
        start = 3'b100; clear = 3'b100; run(2);
        start = 3'b001; run(3);
        rst = 1'b1; run(2);

        // Limit 0, limit rewrite below count, out-of-range channel write.
        rd_ch = 2'd0;
        write_limit(0, 0);
        start = 3'b001; run(3);
        rd_ch = 2'd1;
        write_limit(1, 8);
        start = 3'b010; run(5);
        write_limit(1, 2);
        run(3);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_limit = CW'(0); run(1);
        start = 3'b111; run(4);
        rd_ch = 2'd3; run(2);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NCH; i++) begin
                start[i] = ($urandom_range(0, 29) == 0);
                clear[i] = ($urandom_range(0, 49) == 0);
                en[i]    = ($urandom_range(0, 99) < 85);
                if ($urandom_range(0, 99) == 0) periodic[i] = ~periodic[i];
            end
            cfg_we    = ($urandom_range(0, 14) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_limit = CW'($urandom_range(0, 12));
            rd_ch     = 2'($urandom_range(0, 3));
            step();
        end

        stim_done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
